// File: rtl/mfm_pkg.sv
// Shared types and constants for the MFM write path.
package mfm_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLOCK = 2'd1,
        DATA  = 2'd2
    } mfm_state_e;

    localparam int unsigned DEF_HALF_CELL_CYCLES = 5;
    localparam int unsigned DEF_PULSE_CYCLES     = 5;

    localparam logic [7:0]  A1_BYTE              = 8'hA1;
    localparam logic [15:0] A1_ENCODED           = 16'h4489;
    localparam logic [2:0]  A1_MISSING_CLOCK_IDX = 3'd2;

    // MFM clock bit: a pulse only between two zero data bits, unless an address mark removes it.
    function automatic logic mfm_clock_bit(input logic prev_d, input logic d, input logic suppress);
        return !prev_d && !d && !suppress;
    endfunction

endpackage

// File: rtl/mfm_cell_timer.sv
// Half-cell timing and write-pulse width generation for the MFM write path.
module mfm_cell_timer #(
    parameter int unsigned HALF_CELL_CYCLES = 5,
    parameter int unsigned PULSE_CYCLES     = 5
) (
    input  logic clk_50,
    input  logic rst_n,
    input  logic run,
    input  logic start,
    input  logic fire,
    output logic half_end_c,
    output logic pulse_active_c
);
    localparam int unsigned HC_W = (HALF_CELL_CYCLES > 1) ? $clog2(HALF_CELL_CYCLES) : 1;
    localparam int unsigned PC_W = $clog2(PULSE_CYCLES + 1);

    logic [HC_W-1:0] hc;
    logic [PC_W-1:0] pc;

    assign half_end_c     = (hc == HC_W'(HALF_CELL_CYCLES - 1));
    // A new half cell decides the pulse immediately; otherwise the remaining width keeps it high.
    assign pulse_active_c = start ? fire : (pc != '0);

    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            hc <= '0;
            pc <= '0;
        end else begin
            if (start || !run || half_end_c) begin
                hc <= '0;
            end else begin
                hc <= hc + HC_W'(1);
            end

            if (start) begin
                pc <= fire ? PC_W'(PULSE_CYCLES - 1) : '0;
            end else if (pc != '0) begin
                pc <= pc - PC_W'(1);
            end
        end
    end

endmodule

// File: rtl/mfm_write_encoder.sv
// Byte-serial MFM write encoder: valid/ready bytes in, fixed-width raw_mfm write pulses out.
module mfm_write_encoder
    import mfm_pkg::*;
#(
    parameter int unsigned HALF_CELL_CYCLES = DEF_HALF_CELL_CYCLES,
    parameter int unsigned PULSE_CYCLES     = DEF_PULSE_CYCLES
) (
    input  logic       clk_50,
    input  logic       rst_n,
    input  logic [7:0] data_in,
    input  logic       mark_in,
    input  logic       data_valid,
    output logic       data_ready,
    output logic       raw_mfm,
    output logic       write_active
);
    mfm_state_e state, state_d;

    logic [7:0] hold_data, shift_data;
    logic       hold_mark, shift_mark;
    logic       hold_full, hold_full_d;
    logic [2:0] bit_idx;

    logic       accept_c, load_c, advance_c;
    logic       start_c, fire_c, half_end_c, pulse_active_c;
    logic       cur_bit_c, next_bit_c;
    logic [2:0] next_idx_c;

    assign accept_c   = data_valid && data_ready;
    assign cur_bit_c  = shift_data[bit_idx];
    assign next_idx_c = bit_idx - 3'd1;
    assign next_bit_c = shift_data[next_idx_c];

    mfm_cell_timer #(
        .HALF_CELL_CYCLES (HALF_CELL_CYCLES),
        .PULSE_CYCLES     (PULSE_CYCLES)
    ) u_cell_timer (
        .clk_50         (clk_50),
        .rst_n          (rst_n),
        .run            (state != IDLE),
        .start          (start_c),
        .fire           (fire_c),
        .half_end_c     (half_end_c),
        .pulse_active_c (pulse_active_c)
    );

    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // The previous data bit is the current shift bit at the DATA->CLOCK edge, so the
    // clock bit of the next cell is decided there without a separate prev register.
    always_comb begin
        state_d     = state;
        load_c      = 1'b0;
        advance_c   = 1'b0;
        start_c     = 1'b0;
        fire_c      = 1'b0;
        unique case (state)
            IDLE: begin
                if (hold_full) begin
                    load_c  = 1'b1;
                    start_c = 1'b1;
                    fire_c  = mfm_clock_bit(1'b0, hold_data[7], 1'b0);
                    state_d = CLOCK;
                end
            end
            CLOCK: begin
                if (half_end_c) begin
                    start_c = 1'b1;
                    fire_c  = cur_bit_c;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (half_end_c) begin
                    if (bit_idx != 3'd0) begin
                        advance_c = 1'b1;
                        start_c   = 1'b1;
                        fire_c    = mfm_clock_bit(cur_bit_c, next_bit_c,
                                                  shift_mark && (next_idx_c == A1_MISSING_CLOCK_IDX));
                        state_d   = CLOCK;
                    end else if (hold_full) begin
                        load_c  = 1'b1;
                        start_c = 1'b1;
                        fire_c  = mfm_clock_bit(cur_bit_c, hold_data[7], 1'b0);
                        state_d = CLOCK;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        hold_full_d = hold_full;
        if (accept_c) begin
            hold_full_d = 1'b1;
        end else if (load_c) begin
            hold_full_d = 1'b0;
        end
    end

    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            hold_data    <= '0;
            hold_mark    <= 1'b0;
            hold_full    <= 1'b0;
            shift_data   <= '0;
            shift_mark   <= 1'b0;
            bit_idx      <= 3'd7;
            data_ready   <= 1'b1;
            raw_mfm      <= 1'b0;
            write_active <= 1'b0;
        end else begin
            hold_full    <= hold_full_d;
            data_ready   <= !hold_full_d;
            raw_mfm      <= pulse_active_c;
            write_active <= (state_d != IDLE);
            if (accept_c) begin
                hold_data <= data_in;
                hold_mark <= mark_in;
            end
            if (load_c) begin
                shift_data <= hold_data;
                shift_mark <= hold_mark;
                bit_idx    <= 3'd7;
            end else if (advance_c) begin
                bit_idx <= next_idx_c;
            end
        end
    end

endmodule

// File: tb/tb_mfm_write_encoder.sv
// Scoreboard bench for mfm_write_encoder: driver queues expected cell patterns, monitor captures pulses.
`timescale 1ns/1ps
module tb_mfm_write_encoder;
    localparam int unsigned H           = 5;
    localparam int unsigned P           = 5;
    localparam int unsigned BYTE_CYCLES = 16 * H;

    logic       clk_50     = 1'b0;
    logic       rst_n      = 1'b0;
    logic [7:0] data_in    = 8'h00;
    logic       mark_in    = 1'b0;
    logic       data_valid = 1'b0;
    logic       data_ready, raw_mfm, write_active;

    int checks = 0;
    int errors = 0;

    logic [15:0] exp_pat_q[$];
    logic [7:0]  exp_byte_q[$];
    int          exp_len_q[$];

    logic [7:0]  bd[8];
    logic        bm[8];
    logic [15:0] bp[8];

    logic        mon_s[BYTE_CYCLES];
    int          mon_cnt, mon_burst, mon_bad, mon_len;
    bit          mon_in_burst;
    logic [15:0] mon_pat, mon_exp;
    logic [7:0]  mon_byte;
    logic        mon_bit;

    mfm_write_encoder #(
        .HALF_CELL_CYCLES (H),
        .PULSE_CYCLES     (P)
    ) dut (
        .clk_50       (clk_50),
        .rst_n        (rst_n),
        .data_in      (data_in),
        .mark_in      (mark_in),
        .data_valid   (data_valid),
        .data_ready   (data_ready),
        .raw_mfm      (raw_mfm),
        .write_active (write_active)
    );

    always #10 clk_50 = ~clk_50;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference MFM encoding: each data bit becomes (clock, data); clock only between two zeros.
    function automatic logic [15:0] mfm_model(input logic [7:0] b, input logic m, input logic p);
        logic [15:0] r;
        logic        prev, d, c;
        r    = '0;
        prev = p;
        for (int i = 7; i >= 0; i--) begin
            d    = b[i];
            c    = (prev == 1'b0) && (d == 1'b0) && !(m && i == 2);
            r    = {r[13:0], c, d};
            prev = d;
        end
        return r;
    endfunction

    task automatic offer(input logic [7:0] b, input logic m, output bit ok);
        logic ready_now;
        @(negedge clk_50);
        data_in    = b;
        mark_in    = m;
        data_valid = 1'b1;
        ok         = 1'b0;
        for (int w = 0; w < 300 && !ok; w++) begin
            ready_now = data_ready;
            @(posedge clk_50);
            if (ready_now === 1'b1) ok = 1'b1;
            #1;
        end
        data_valid = 1'b0;
        mark_in    = 1'b0;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL handshake_timeout: byte %0h not accepted within 300 cycles", b);
        end
    endtask

    task automatic wait_idle(input int budget);
        int w;
        w = 0;
        while (write_active !== 1'b0 && w < budget) begin
            @(posedge clk_50);
            #1;
            w++;
        end
        if (write_active !== 1'b0) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: write_active still %b after %0d cycles", write_active, budget);
        end
        repeat (5) @(posedge clk_50);
        #1;
    endtask

    task automatic send_burst(input int n, input int max_delay);
        bit ok;
        exp_len_q.push_back(n * BYTE_CYCLES);
        for (int i = 0; i < n; i++) begin
            exp_pat_q.push_back(bp[i]);
            exp_byte_q.push_back(bd[i]);
            if (i > 0 && max_delay > 0) repeat ($urandom_range(max_delay, 0)) @(negedge clk_50);
            offer(bd[i], bm[i], ok);
            if (i == 0) begin
                check("idle_at_handshake", write_active, 1'b0);
                @(posedge clk_50);
                #1;
                check("start_latency", write_active, 1'b1);
                check("first_cell_pulse", raw_mfm, bp[0][15]);
            end
        end
        wait_idle(n * BYTE_CYCLES + 100);
    endtask

    // Monitor: samples each cycle, decodes one 16-half-cell pattern per 80 active cycles.
    initial begin
        mon_cnt      = 0;
        mon_burst    = 0;
        mon_in_burst = 1'b0;
        forever begin
            @(negedge clk_50);
            if (!rst_n) begin
                mon_cnt      = 0;
                mon_burst    = 0;
                mon_in_burst = 1'b0;
            end else if (write_active === 1'b1) begin
                mon_in_burst   = 1'b1;
                mon_s[mon_cnt] = raw_mfm;
                mon_cnt++;
                mon_burst++;
                if (mon_cnt == BYTE_CYCLES) begin
                    mon_cnt = 0;
                    mon_bad = 0;
                    mon_pat = '0;
                    for (int h = 0; h < 16; h++) begin
                        mon_bit         = mon_s[h * H];
                        mon_pat[15 - h] = mon_bit;
                        for (int j = 0; j < H; j++) begin
                            if (mon_s[h * H + j] !== (mon_bit && (j < P))) mon_bad++;
                        end
                    end
                    check("pulse_shape_bad_cycles", mon_bad, 0);
                    if (exp_pat_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_byte: pattern %04h with nothing expected", mon_pat);
                    end else begin
                        mon_exp  = exp_pat_q.pop_front();
                        mon_byte = exp_byte_q.pop_front();
                        checks++;
                        if (mon_pat !== mon_exp) begin
                            errors++;
                            $display("FAIL cell_pattern byte %02h: got %04h, expected %04h",
                                     mon_byte, mon_pat, mon_exp);
                        end
                    end
                end
            end else if (mon_in_burst) begin
                mon_in_burst = 1'b0;
                if (exp_len_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_burst: %0d active cycles with nothing expected", mon_burst);
                end else begin
                    mon_len = exp_len_q.pop_front();
                    check("write_active_cycles", mon_burst, mon_len);
                end
                mon_cnt   = 0;
                mon_burst = 0;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        errors++;
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit   ok;
        logic p;
        int   n, quiet_bad;

        rst_n = 1'b0;
        repeat (3) @(posedge clk_50);
        #1;
        check("reset_raw_mfm", raw_mfm, 1'b0);
        check("reset_write_active", write_active, 1'b0);
        check("reset_data_ready", data_ready, 1'b1);
        @(posedge clk_50);
        #3 rst_n = 1'b1;
        repeat (3) @(posedge clk_50);

        bd[0] = 8'h00; bm[0] = 1'b0; bp[0] = 16'hAAAA;
        send_burst(1, 0);
        bd[0] = 8'hFF; bm[0] = 1'b0; bp[0] = 16'h5555;
        send_burst(1, 0);
        bd[0] = 8'hA1; bm[0] = 1'b1; bp[0] = 16'h4489;
        send_burst(1, 0);
        bd[0] = 8'hA1; bm[0] = 1'b0; bp[0] = 16'h44A9;
        send_burst(1, 0);

        // Streamed 00/FF/00: third byte's first clock is dropped after the trailing 1.
        bd[0] = 8'h00; bm[0] = 1'b0; bp[0] = 16'hAAAA;
        bd[1] = 8'hFF; bm[1] = 1'b0; bp[1] = 16'h5555;
        bd[2] = 8'h00; bm[2] = 1'b0; bp[2] = 16'h2AAA;
        send_burst(3, 0);

        // Mark pair: A1 mark then A1 mark streamed; second A1 starts after data bit 1.
        bd[0] = 8'hA1; bm[0] = 1'b1; bp[0] = 16'h4489;
        bd[1] = 8'hA1; bm[1] = 1'b1; bp[1] = 16'h4489;
        bd[2] = 8'h00; bm[2] = 1'b0; bp[2] = 16'h2AAA;
        send_burst(3, 10);

        // Reset mid-byte with a second byte held.
        offer(8'h00, 1'b0, ok);
        @(posedge clk_50);
        offer(8'h55, 1'b0, ok);
        repeat (29) @(posedge clk_50);
        #2;
        check("raw_before_reset", raw_mfm, 1'b1);
        check("ready_while_held", data_ready, 1'b0);
        rst_n = 1'b0;
        #1;
        check("async_reset_raw_mfm", raw_mfm, 1'b0);
        check("async_reset_data_ready", data_ready, 1'b1);
        check("async_reset_write_active", write_active, 1'b0);
        repeat (3) @(posedge clk_50);
        #3 rst_n = 1'b1;
        quiet_bad = 0;
        for (int c = 0; c < 120; c++) begin
            @(posedge clk_50);
            #1;
            if (write_active !== 1'b0 || raw_mfm !== 1'b0) quiet_bad++;
        end
        check("post_reset_quiet_bad_cycles", quiet_bad, 0);

        bd[0] = 8'h00; bm[0] = 1'b0; bp[0] = 16'hAAAA;
        send_burst(1, 0);

        // Randomized bursts against the reference encoder.
        for (int b = 0; b < 8; b++) begin
            n = int'($urandom_range(4, 1));
            p = 1'b0;
            for (int i = 0; i < n; i++) begin
                bd[i] = 8'($urandom_range(255, 0));
                bm[i] = ($urandom_range(3, 0) == 0);
                bp[i] = mfm_model(bd[i], bm[i], p);
                p     = bd[i][0];
            end
            send_burst(n, 30);
        end

        repeat (10) @(posedge clk_50);
        check("leftover_expected_bytes", exp_pat_q.size(), 0);
        check("leftover_expected_bursts", exp_len_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
